vector_response_checker: RTL and testbench
==========================================

Name: vector_response_checker

Overview:
- Synthesizable on-chip counterpart to our directed stimulus benches.
- Drives every input combination of a small combinational DUT and waits a programmable settle time per vector.
- Samples the DUT response and compares it against a golden truth table; reports pass/fail, error count and first failing vector.
- Sits beside the DUT in lab top-levels so self-test runs on hardware without a simulator.

Parameters:
- N_IN, 2, DUT input width; vector space is 2**N_IN (legal range 1..8).
- EXPECT_MASK, 4'b0010, golden truth table of width 2**N_IN; bit i = expected DUT output for applied vector value i (default encodes y = ~a & b with stim = {a,b}).
- SETTLE, 4, clock cycles between driving a vector and sampling the response (legal range 1..255).
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse; begins a sweep when idle
- dut_y  input  1  DUT response under test
- stim  output  N_IN  vector driven to the DUT inputs
- busy  output  1  high while a sweep is in progress
- done  output  1  single-cycle pulse when the sweep completes
- pass  output  1  high after a sweep with zero mismatches; held until the next start
- err_count  output  ERR_W  mismatch count, saturating
- first_fail  output  N_IN  vector value of the first mismatch
- first_fail_vld  output  1  first_fail is valid

Behaviour:
- Reset (async, active-high): state=IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, first_fail_vld=0.
- All outputs are registered.
- FSM states: IDLE, DRIVE, SAMPLE, NEXT, FINISH.
- IDLE:
  - start=1 moves to DRIVE.
  - Same edge: index=0, stim=vec(0), err_count=0, first_fail_vld=0, pass=0, busy=1.
- DRIVE:
  - The settle counter loads SETTLE-1 on entry and decrements each cycle.
  - At 0, move to SAMPLE.
  - stim is stable for exactly SETTLE cycles before sampling.
- SAMPLE: compare dut_y with EXPECT_MASK[stim], i.e. indexed by the applied value, not the sweep index. On mismatch:
  - err_count increments, saturating at all-ones.
  - If first_fail_vld=0, capture first_fail=stim and set first_fail_vld=1.
- NEXT:
  - If index == 2**N_IN-1, go to FINISH.
  - Otherwise index+1, stim=vec(index+1), and return to DRIVE.
  - The index counter is N_IN+1 bits so the last-vector test never wraps.
- FINISH:
  - done=1 for one cycle, busy=0, pass=(err_count==0).
  - Return to IDLE next cycle.
  - stim holds its last vector until the next start.
- Per-vector latency is SETTLE+2 cycles. Sweep length is 2**N_IN*(SETTLE+2) cycles from start to done.
- start while busy is ignored. No restart and no queueing.
- start in the same cycle as done is ignored; it is accepted only in IDLE.
- reset mid-sweep aborts immediately to reset values. No done pulse.
- dut_y is assumed synchronous to clk or settled. The block adds no synchronizer.

Optional Feature:
- CHECKER_GRAY_EN defined: vec(i) = i ^ (i >> 1), i.e. Gray order, so each step flips one input bit (00, 01, 11, 10 for N_IN=2). This isolates single-input transition glitches.
- Not defined: vec(i) = i, binary order (00, 01, 10, 11).
- Comparison always uses EXPECT_MASK[stim], so pass/fail results are identical in both builds. Only first_fail may differ when several vectors fail.

Decomposition:
- Package vrc_pkg holds:
  - state_t enum {IDLE, DRIVE, SAMPLE, NEXT, FINISH}
  - function bin2gray
  - constant SETTLE_W = 8
- One sub-module, settle_timer: load/decrement down-counter with a zero flag, used by DRIVE.

Test Plan:
- Correct DUT (y = ~a & b), SETTLE=4, pulse start -> stim sequence 00, 01, 10, 11 (Gray build: 00, 01, 11, 10), each held 4 cycles before sampling. done after 24 cycles; pass=1, err_count=0, first_fail_vld=0.
- Faulty DUT (y = a & b) -> mismatches at vectors 01 and 11. err_count=2, pass=0, first_fail=01 (both builds), first_fail_vld=1.
- Stuck-at-1 DUT, ERR_W=1, N_IN=2 -> err_count saturates at 1, pass=0, first_fail=00.
- start pulsed again at cycle 10 of a sweep -> ignored. Sweep still ends at cycle 24 with a single done pulse.
- Assert reset at cycle 13 mid-sweep -> all outputs return to reset values asynchronously and no done pulse occurs. A new start yields a full clean sweep.
- SETTLE=1, N_IN=3, EXPECT_MASK=8'h96 against a 3-input XOR DUT -> pass=1 after 24 cycles. Wrap check: index reaches 7 and FINISH is entered, with no ninth vector driven.

Source files
------------

// File: rtl/vrc_pkg.sv
// rtl/vrc_pkg.sv - shared types and helpers for the vector response checker
package vrc_pkg;

    localparam int SETTLE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        NEXT,
        FINISH
    } state_t;

    function automatic logic [SETTLE_W-1:0] bin2gray(input logic [SETTLE_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/vector_response_checker_settle_timer.sv
// rtl/vector_response_checker_settle_timer.sv - load/decrement settle down-counter with zero flag
module settle_timer
    import vrc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [SETTLE_W-1:0] i_load_val,
    input  logic                i_dec,
    output logic                o_zero
);

    logic [SETTLE_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/vector_response_checker.sv
// rtl/vector_response_checker.sv - exhaustive stimulus sweep and golden-table response checker
// Optional build macro CHECKER_GRAY_EN selects Gray-order sweep instead of binary order.
module vector_response_checker
    import vrc_pkg::*;
#(
    parameter int                  N_IN        = 2,
    parameter logic [2**N_IN-1:0]  EXPECT_MASK = 4'b0010,
    parameter int                  SETTLE      = 4,
    parameter int                  ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dut_y,
    output logic [N_IN-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [N_IN-1:0]  first_fail,
    output logic             first_fail_vld
);

    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE - 1);
    // One extra index bit keeps the last-vector compare from aliasing to zero.
    localparam logic [N_IN:0]       IDX_LAST  = (N_IN + 1)'(2**N_IN - 1);

    function automatic logic [N_IN-1:0] vec(input logic [N_IN-1:0] i);
`ifdef CHECKER_GRAY_EN
        return N_IN'(bin2gray(SETTLE_W'(i)));
`else
        return i;
`endif
    endfunction

    state_t           r_state;
    logic [N_IN:0]    r_idx;
    logic [N_IN-1:0]  r_stim;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic [N_IN-1:0]  r_ff;
    logic             r_ff_vld;

    logic             w_last;
    logic [N_IN:0]    w_idx_nxt;
    logic             w_load;
    logic             w_dec;
    logic             w_zero;
    logic             w_mismatch;

    assign w_last     = (r_idx == IDX_LAST);
    assign w_idx_nxt  = r_idx + (N_IN + 1)'(1);
    assign w_load     = ((r_state == IDLE) && start) || ((r_state == NEXT) && !w_last);
    assign w_dec      = (r_state == DRIVE);
    assign w_mismatch = (dut_y != EXPECT_MASK[r_stim]);

    settle_timer u_settle_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (SETTLE_LD),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_stim   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
            r_ff     <= '0;
            r_ff_vld <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state  <= DRIVE;
                        r_idx    <= '0;
                        r_stim   <= vec('0);
                        r_err    <= '0;
                        r_ff_vld <= 1'b0;
                        r_pass   <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (w_zero) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    // Golden bit is looked up by the applied value so both sweep orders agree.
                    if (w_mismatch) begin
                        if (r_err != '1) begin
                            r_err <= r_err + 1'b1;
                        end
                        if (!r_ff_vld) begin
                            r_ff     <= r_stim;
                            r_ff_vld <= 1'b1;
                        end
                    end
                    r_state <= NEXT;
                end
                NEXT: begin
                    if (w_last) begin
                        r_state <= FINISH;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (r_err == '0);
                    end else begin
                        r_idx   <= w_idx_nxt;
                        r_stim  <= vec(w_idx_nxt[N_IN-1:0]);
                        r_state <= DRIVE;
                    end
                end
                FINISH: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign stim           = r_stim;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_fail     = r_ff;
    assign first_fail_vld = r_ff_vld;

endmodule

// File: tb/tb_vector_response_checker.sv
// tb/tb_vector_response_checker.sv - randomized self-checking bench for vector_response_checker
module tb_vector_response_checker;

    logic clk = 1'b0;
    logic rst;
    logic start_r;
    int   sel;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    logic [3:0] tbl_a, tbl_b;
    logic [7:0] tbl_c;

    logic       start_a, start_b, start_c;
    logic       y_a, y_b, y_c;
    logic [1:0] stim_a, stim_b, ff_a, ff_b;
    logic [2:0] stim_c, ff_c;
    logic       busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic       pass_a, pass_b, pass_c, vld_a, vld_b, vld_c;
    logic [7:0] err_a, err_c;
    logic [0:0] err_b;

    assign start_a = start_r && (sel == 0);
    assign start_b = start_r && (sel == 1);
    assign start_c = start_r && (sel == 2);
    assign y_a = tbl_a[stim_a];
    assign y_b = tbl_b[stim_b];
    assign y_c = tbl_c[stim_c];

    vector_response_checker #(.N_IN(2), .EXPECT_MASK(4'b0010), .SETTLE(4), .ERR_W(8)) u_a (
        .clk(clk), .reset(rst), .start(start_a), .dut_y(y_a), .stim(stim_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .err_count(err_a), .first_fail(ff_a), .first_fail_vld(vld_a));

    vector_response_checker #(.N_IN(2), .EXPECT_MASK(4'b0010), .SETTLE(4), .ERR_W(1)) u_b (
        .clk(clk), .reset(rst), .start(start_b), .dut_y(y_b), .stim(stim_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .err_count(err_b), .first_fail(ff_b), .first_fail_vld(vld_b));

    vector_response_checker #(.N_IN(3), .EXPECT_MASK(8'h96), .SETTLE(1), .ERR_W(8)) u_c (
        .clk(clk), .reset(rst), .start(start_c), .dut_y(y_c), .stim(stim_c), .busy(busy_c),
        .done(done_c), .pass(pass_c), .err_count(err_c), .first_fail(ff_c), .first_fail_vld(vld_c));

    logic [7:0] o_stim, o_err, o_ff;
    logic       o_busy, o_done, o_pass, o_vld;

    always_comb begin
        o_stim = {6'd0, stim_a}; o_err = err_a; o_ff = {6'd0, ff_a};
        o_busy = busy_a; o_done = done_a; o_pass = pass_a; o_vld = vld_a;
        if (sel == 1) begin
            o_stim = {6'd0, stim_b}; o_err = {7'd0, err_b}; o_ff = {6'd0, ff_b};
            o_busy = busy_b; o_done = done_b; o_pass = pass_b; o_vld = vld_b;
        end else if (sel == 2) begin
            o_stim = {5'd0, stim_c}; o_err = err_c; o_ff = {5'd0, ff_c};
            o_busy = busy_c; o_done = done_c; o_pass = pass_c; o_vld = vld_c;
        end
    end

    function automatic int vec_of(input int i);
`ifdef CHECKER_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_stim"}, 32'(o_stim), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_pass"}, 32'(o_pass), 32'd0);
        check({tag, "_err"},  32'(o_err),  32'd0);
        check({tag, "_ff"},   32'(o_ff),   32'd0);
        check({tag, "_vld"},  32'(o_vld),  32'd0);
    endtask

    // One sweep on instance s_sel; restart_j / reset_j are cycles after the start edge (-1 = none).
    task automatic sweep(input int s_sel, input int restart_j, input int reset_j);
        int n, s, ew, t_len, errs, first, emax, exp_err;
        logic [7:0] m, tb;
        sel = s_sel;
        n  = (s_sel == 2) ? 3 : 2;
        s  = (s_sel == 2) ? 1 : 4;
        ew = (s_sel == 1) ? 1 : 8;
        m  = (s_sel == 2) ? 8'h96 : 8'h02;
        tb = (s_sel == 0) ? {4'd0, tbl_a} : (s_sel == 1) ? {4'd0, tbl_b} : tbl_c;
        t_len = (1 << n) * (s + 2);
        errs = 0;
        first = -1;
        for (int i = 0; i < (1 << n); i++) begin
            int v;
            v = vec_of(i);
            if (tb[v] != m[v]) begin
                errs++;
                if (first < 0) first = v;
            end
        end
        emax = (1 << ew) - 1;
        exp_err = (errs > emax) ? emax : errs;

        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        for (int j = 0; j <= t_len + 1; j++) begin
            int ev;
            ev = (j < t_len) ? vec_of(j / (s + 2)) : vec_of((1 << n) - 1);
            check("stim", 32'(o_stim), 32'(ev));
            check("busy", 32'(o_busy), 32'(j < t_len));
            check("done", 32'(o_done), 32'(j == t_len));
            if (j >= t_len) begin
                check("pass", 32'(o_pass), 32'(errs == 0));
                check("err_count", 32'(o_err), 32'(exp_err));
                check("first_fail_vld", 32'(o_vld), 32'(errs != 0));
                if (errs != 0) check("first_fail", 32'(o_ff), 32'(first));
            end
            if (j == reset_j) begin
                #2;
                rst = 1'b1;
                #1;
                check_reset_values("async_reset");
                @(negedge clk);
                rst = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk);
                    #1;
                    check("no_done_after_abort", 32'(o_done), 32'd0);
                    check("idle_after_abort", 32'(o_busy), 32'd0);
                end
                return;
            end
            start_r = (j == restart_j);
            @(posedge clk);
            #1;
        end
        start_r = 1'b0;
        @(posedge clk);
        #1;
        check("stays_idle", 32'(o_busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start_r = 1'b0;
        sel = 0;
        tbl_a = 4'b0010;
        tbl_b = 4'b1111;
        tbl_c = 8'h96;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            check_reset_values("reset");
        end
        @(negedge clk);
        rst = 1'b0;

        tbl_a = 4'b0010;
        sweep(0, -1, -1);
        tbl_a = 4'b1000;
        sweep(0, 10, -1);
        tbl_a = 4'b0010;
        sweep(0, -1, 13);
        sweep(0, -1, -1);
        tbl_a = 4'b1000;
        sweep(0, 24, -1);
        for (int r = 0; r < 6; r++) begin
            tbl_a = 4'($urandom);
            sweep(0, -1, -1);
        end

        tbl_b = 4'b1111;
        sweep(1, -1, -1);
        for (int r = 0; r < 3; r++) begin
            tbl_b = 4'($urandom);
            sweep(1, -1, -1);
        end

        tbl_c = 8'h96;
        sweep(2, -1, -1);
        for (int r = 0; r < 4; r++) begin
            tbl_c = 8'($urandom);
            sweep(2, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
